// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: single-write, dual-read data memory with a built-in clear/preload
// sequencer. After Reset the array is swept once. Every word is written with 0, except
// INIT_ADDR_A (INIT_VAL_A) and INIT_ADDR_B (INIT_VAL_B); A wins if the two are equal.
// busy stays high until the sweep completes.
//
// Ports:
//   clk, Reset      clock, synchronous active-high reset
//   write_en        port A write strobe (honoured only in READY)
//   addr            port A read/write address
//   data_in         port A write data
//   data_out        port A read data (READ_LAT 0: combinational, 1: registered write-first)
//   rd_addr_b       port B read address
//   data_out_b      port B read data (same latency as port A; forwards on address match)
//   busy            high from Reset until the clear sweep has finished
//   wr_ignored      one-cycle pulse after an in-range write was dropped during the sweep
module data_mem_ctrl #(
    parameter int DW          = 8,
    parameter int AW          = 8,
    parameter int DEPTH       = 256,
    parameter int READ_LAT    = 0,
    parameter int INIT_ADDR_A = 16,
    parameter int INIT_VAL_A  = 254,
    parameter int INIT_ADDR_B = 244,
    parameter int INIT_VAL_B  = 5
) (
    input  logic          clk,
    input  logic          Reset,
    input  logic          write_en,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] data_in,
    output logic [DW-1:0] data_out,
    input  logic [AW-1:0] rd_addr_b,
    output logic [DW-1:0] data_out_b,
    output logic          busy,
    output logic          wr_ignored
);

    localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH);
    localparam logic [AW:0]   LAST    = (AW+1)'(DEPTH - 1);
    localparam logic [AW:0]   IA      = (AW+1)'(INIT_ADDR_A);
    localparam logic [AW:0]   IB      = (AW+1)'(INIT_ADDR_B);
    localparam logic [DW-1:0] VA      = DW'(INIT_VAL_A);
    localparam logic [DW-1:0] VB      = DW'(INIT_VAL_B);

    typedef enum logic {CLEAR, READY} state_t;

    state_t        state_q, state_d;
    logic [AW:0]   clr_ptr_q, clr_ptr_d;   // one extra bit so the terminal compare never wraps
    logic          busy_q, wr_ign_q;
    logic [DW-1:0] clr_val;
    logic [DW-1:0] rd_a, rd_b;
    logic          a_ok, b_ok;

    logic [DW-1:0] core [DEPTH];

    assign a_ok = {1'b0, addr}      < DEPTH_W;
    assign b_ok = {1'b0, rd_addr_b} < DEPTH_W;

    // next state / sweep pointer
    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        if (state_q == CLEAR) begin
            clr_ptr_d = clr_ptr_q + 1'b1;
            if (clr_ptr_q == LAST) state_d = READY;
        end
    end

    // preload value for the word being swept; A takes priority over B
    always_comb begin
        clr_val = '0;
        if (clr_ptr_q == IA)      clr_val = VA;
        else if (clr_ptr_q == IB) clr_val = VB;
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q   <= CLEAR;
            clr_ptr_q <= '0;
            busy_q    <= 1'b1;
            wr_ign_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
            // registered from next state so busy drops right after the last sweep edge
            busy_q    <= (state_d != READY);
            wr_ign_q  <= (state_q == CLEAR) && write_en && a_ok;
        end
    end

    // array: sweep writes own the port during CLEAR; out-of-range writes are dropped
    always_ff @(posedge clk) begin
        if (!Reset) begin
            if (state_q == CLEAR)
                core[clr_ptr_q[AW-1:0]] <= clr_val;
            else if (write_en && a_ok)
                core[addr] <= data_in;
        end
    end

    assign rd_a = a_ok ? core[addr]      : '0;
    assign rd_b = b_ok ? core[rd_addr_b] : '0;

    generate
        if (READ_LAT == 0) begin : g_comb
            assign data_out   = busy_q ? '0 : rd_a;
            assign data_out_b = busy_q ? '0 : rd_b;
        end else begin : g_reg
            logic [DW-1:0] dout_q, dout_b_q;
            always_ff @(posedge clk) begin
                if (Reset || busy_q) begin
                    dout_q   <= '0;
                    dout_b_q <= '0;
                end else begin
                    // write-first: a same-cycle write is returned instead of the old word
                    dout_q   <= (write_en && a_ok) ? data_in : rd_a;
                    dout_b_q <= (write_en && a_ok && rd_addr_b == addr) ? data_in : rd_b;
                end
            end
            assign data_out   = dout_q;
            assign data_out_b = dout_b_q;
        end
    endgenerate

    assign busy       = busy_q;
    assign wr_ignored = wr_ign_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
module tb_data_mem_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // u0: defaults, READ_LAT=0
    logic       r0 = 1'b1, we0 = 1'b0, bz0, wi0;
    logic [7:0] a0 = '0, d0 = '0, q0, b0 = '0, qb0;
    // u1: defaults, READ_LAT=1
    logic       r1 = 1'b1, we1 = 1'b0, bz1, wi1;
    logic [7:0] a1 = '0, d1 = '0, q1, b1 = '0, qb1;
    // u2: small memory, out-of-range addresses exist
    logic        r2 = 1'b1, we2 = 1'b0, bz2, wi2;
    logic [3:0]  a2 = '0, b2 = '0;
    logic [15:0] d2 = '0, q2, qb2;

    data_mem_ctrl u0 (.clk(clk), .Reset(r0), .write_en(we0), .addr(a0), .data_in(d0),
        .data_out(q0), .rd_addr_b(b0), .data_out_b(qb0), .busy(bz0), .wr_ignored(wi0));

    data_mem_ctrl #(.READ_LAT(1)) u1 (.clk(clk), .Reset(r1), .write_en(we1), .addr(a1),
        .data_in(d1), .data_out(q1), .rd_addr_b(b1), .data_out_b(qb1), .busy(bz1),
        .wr_ignored(wi1));

    data_mem_ctrl #(.DW(16), .AW(4), .DEPTH(12), .INIT_ADDR_A(2), .INIT_VAL_A(16'hBEEF),
        .INIT_ADDR_B(11), .INIT_VAL_B(1)) u2 (.clk(clk), .Reset(r2), .write_en(we2),
        .addr(a2), .data_in(d2), .data_out(q2), .rd_addr_b(b2), .data_out_b(qb2),
        .busy(bz2), .wr_ignored(wi2));

    int nvec = 0, nerr = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // counts edges until the selected DUT drops busy; bounded
    task automatic wait_fall(input int which, input int already, output int n);
        logic b;
        n = already;
        b = (which == 0) ? bz0 : (which == 1) ? bz1 : bz2;
        while (b && n < 2000) begin
            tick();
            n++;
            b = (which == 0) ? bz0 : (which == 1) ? bz1 : bz2;
        end
    endtask

    int n;

    initial begin
        // ---- u0: reset state and clear time ----
        repeat (3) tick();
        chk("u0 busy in reset", bz0, 1);
        chk("u0 wr_ignored in reset", wi0, 0);
        chk("u0 data_out in reset", q0, 0);
        r0 = 1'b0;
        wait_fall(0, 0, n);
        chk("u0 clear cycles", n, 256);
        a0 = 8'd16;  #1 chk("u0 rd 16", q0, 8'hFE);
        a0 = 8'd244; #1 chk("u0 rd 244", q0, 8'd5);
        a0 = 8'd0;   #1 chk("u0 rd 0", q0, 0);
        a0 = 8'd17;  #1 chk("u0 rd 17", q0, 0);
        a0 = 8'd255; #1 chk("u0 rd 255", q0, 0);
        b0 = 8'd16;  #1 chk("u0 rdb 16", qb0, 8'hFE);

        // ---- u0: write in READY, no forwarding ----
        we0 = 1'b1; a0 = 8'd3; d0 = 8'hA5; b0 = 8'd3;
        #1 chk("u0 pre-edge no fwd", q0, 0);
        tick();
        we0 = 1'b0;
        #1;
        chk("u0 rd 3 after wr", q0, 8'hA5);
        chk("u0 rdb 3 after wr", qb0, 8'hA5);

        // ---- u0: write dropped during clear ----
        r0 = 1'b1; tick(); r0 = 1'b0;
        chk("u0 busy after restart", bz0, 1);
        chk("u0 rd while busy", q0, 0);
        repeat (9) tick();
        we0 = 1'b1; a0 = 8'd9; d0 = 8'h11;
        tick();
        we0 = 1'b0;
        chk("u0 wr_ignored pulse", wi0, 1);
        tick();
        chk("u0 wr_ignored clears", wi0, 0);
        wait_fall(0, 11, n);
        chk("u0 clear cycles 2", n, 256);
        a0 = 8'd9; #1 chk("u0 rd 9 dropped", q0, 0);
        a0 = 8'd3; #1 chk("u0 rd 3 recleared", q0, 0);

        // ---- u0: reset mid-clear restarts the sweep ----
        r0 = 1'b1; tick(); r0 = 1'b0;
        repeat (100) tick();
        chk("u0 busy mid clear", bz0, 1);
        r0 = 1'b1; tick(); r0 = 1'b0;
        chk("u0 busy after 2nd reset", bz0, 1);
        wait_fall(0, 0, n);
        chk("u0 clear cycles 3", n, 256);
        a0 = 8'd16;  #1 chk("u0 rd 16 again", q0, 8'hFE);
        a0 = 8'd244; #1 chk("u0 rd 244 again", q0, 8'd5);

        // ---- u1: registered reads with write-first forwarding ----
        chk("u1 data_out in reset", q1, 0);
        chk("u1 data_out_b in reset", qb1, 0);
        r1 = 1'b0;
        wait_fall(1, 0, n);
        chk("u1 clear cycles", n, 256);
        we1 = 1'b1; a1 = 8'd7; d1 = 8'h3C; b1 = 8'd7;
        tick();
        we1 = 1'b0;
        chk("u1 fwd a", q1, 8'h3C);
        chk("u1 fwd b", qb1, 8'h3C);
        tick();
        chk("u1 array a", q1, 8'h3C);
        chk("u1 array b", qb1, 8'h3C);
        we1 = 1'b1; a1 = 8'd8; d1 = 8'h77; b1 = 8'd7;
        tick();
        we1 = 1'b0;
        chk("u1 fwd a 8", q1, 8'h77);
        chk("u1 b no fwd", qb1, 8'h3C);
        a1 = 8'd16;
        #1 chk("u1 latency holds", q1, 8'h77);
        tick();
        chk("u1 rd 16", q1, 8'hFE);

        // ---- u2: small depth, out-of-range address ----
        r2 = 1'b0;
        wait_fall(2, 0, n);
        chk("u2 clear cycles", n, 12);
        a2 = 4'd2;  #1 chk("u2 rd 2", q2, 16'hBEEF);
        a2 = 4'd11; #1 chk("u2 rd 11", q2, 16'h0001);
        a2 = 4'd0;  #1 chk("u2 rd 0", q2, 0);
        we2 = 1'b1; a2 = 4'd14; d2 = 16'h1234;
        tick();
        we2 = 1'b0;
        chk("u2 oor no pulse", wi2, 0);
        #1 chk("u2 rd 14", q2, 0);
        b2 = 4'd14; #1 chk("u2 rdb 14", qb2, 0);
        a2 = 4'd2;  #1 chk("u2 rd 2 intact", q2, 16'hBEEF);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
